// File: rtl/crc16_pkg.sv
// Shared CRC-16 definitions for the frame checker and the transmit-side generator:
// checker FSM state enum, byte bit-reverse, single 16-bit MSB-first CRC step,
// and the final output transform.
package crc16_pkg;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_INFRAME = 1'b1
   } crc_state_e;

   // Reverse the bit order of one byte in place.
   function automatic logic [7:0] bitrev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = b[7-i];
      end
      return r;
   endfunction

   // Reverse each byte of a 16-bit word in place (byte order is kept).
   function automatic logic [15:0] byterev16(input logic [15:0] w);
      return {bitrev8(w[15:8]), bitrev8(w[7:0])};
   endfunction

   // Feed 16 data bits, MSB first, through the CRC register.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                              input logic [15:0] data,
                                              input logic [15:0] poly);
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int i = 15; i >= 0; i--) begin
         fb = c[15] ^ data[i];
         c  = {c[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
      end
      return c;
   endfunction

   // Output transform: bit-reverse each byte in place, then invert.
   function automatic logic [15:0] crc16_final(input logic [15:0] crc);
      return byterev16(crc) ^ 16'hFFFF;
   endfunction

endpackage

// File: rtl/crc16_step2.sv
// Combinational CRC-16 update for one 32-bit beat: up to two 16-bit steps,
// high word first. nwords_i selects 0, 1 (high word only) or 2 words.
module crc16_step2
   import crc16_pkg::*;
#(
   parameter logic [15:0] CRCPOLY = 16'h1021
) (
   input  logic [15:0] crc_i,
   input  logic [31:0] data_i,
   input  logic [1:0]  nwords_i,
   output logic [15:0] crc_o
);

   logic [15:0] hi_word_s;
   logic [15:0] lo_word_s;
   logic [15:0] after_hi_s;
   logic [15:0] after_lo_s;

   // Byte-reverse each data word, chain the two steps, then pick by word count.
   always_comb begin
      hi_word_s  = byterev16(data_i[31:16]);
      lo_word_s  = byterev16(data_i[15:0]);
      after_hi_s = crc16_step(crc_i, hi_word_s, CRCPOLY);
      after_lo_s = crc16_step(after_hi_s, lo_word_s, CRCPOLY);
      case (nwords_i)
         2'd0:    crc_o = crc_i;
         2'd1:    crc_o = after_hi_s;
         2'd2:    crc_o = after_lo_s;
         default: crc_o = after_lo_s;
      endcase
   end

endmodule

// File: rtl/crc16_frame_checker.sv
// CRC-16 receive frame checker. Stage 1 registers the beat and runs the framing
// FSM; stage 2 updates the CRC and produces the one-cycle frame-result pulses.
// Optional statistics counters are built when CRC16_CHECKER_STATS_EN is defined;
// otherwise FRAMECOUNT and ERRCOUNT are tied to zero.
module crc16_frame_checker
   import crc16_pkg::*;
#(
   parameter logic [15:0] CRCINIT = 16'hFFFF,
   parameter logic [15:0] CRCPOLY = 16'h1021
) (
   input  logic        CRCCLK,
   input  logic        CRCRESET,
   input  logic [31:0] RXDATA,
   input  logic        RXVALID,
   input  logic        RXSOF,
   input  logic        RXEOF,
   input  logic        RXHALF,
   output logic        CRCDONE,
   output logic        CRCOK,
   output logic        CRCERR,
   output logic        FRAMEABORT,
   output logic [15:0] RXCRC,
   output logic [15:0] CALCCRC,
   output logic [15:0] FRAMECOUNT,
   output logic [15:0] ERRCOUNT
);

   // Stage 1: accepted beat plus framing decisions
   crc_state_e  state_q;
   logic        s1_valid_q;
   logic        s1_sof_q;
   logic        s1_eof_q;
   logic        s1_half_q;
   logic        s1_abort_q;
   logic [31:0] s1_data_q;

   // Stage 2: running CRC and results
   logic [15:0] crc_q;
   logic        done_q;
   logic        ok_q;
   logic        err_q;
   logic        abort_q;
   logic [15:0] rxcrc_q;
   logic [15:0] calccrc_q;

   logic [1:0]  nwords_d;
   logic [15:0] crc_base_d;
   logic [15:0] crc_next_d;
   logic [15:0] calc_d;
   logic [15:0] rxfield_d;
   logic        done_d;
   logic        match_d;
   logic        abort_d;

   // Framing FSM: admits SOF beats in IDLE, every valid beat in INFRAME, flags aborts.
   always_ff @(posedge CRCCLK or posedge CRCRESET) begin
      if (CRCRESET) begin
         state_q    <= ST_IDLE;
         s1_valid_q <= 1'b0;
         s1_sof_q   <= 1'b0;
         s1_eof_q   <= 1'b0;
         s1_half_q  <= 1'b0;
         s1_abort_q <= 1'b0;
         s1_data_q  <= 32'h0000_0000;
      end else begin
         s1_valid_q <= 1'b0;
         s1_abort_q <= 1'b0;
         s1_sof_q   <= RXSOF;
         s1_eof_q   <= RXEOF;
         s1_half_q  <= RXHALF;
         s1_data_q  <= RXDATA;
         case (state_q)
            ST_IDLE: begin
               if (RXVALID && RXSOF) begin
                  s1_valid_q <= 1'b1;
                  state_q    <= RXEOF ? ST_IDLE : ST_INFRAME;
               end else begin
                  state_q    <= ST_IDLE;
               end
            end
            ST_INFRAME: begin
               if (RXVALID) begin
                  s1_valid_q <= 1'b1;
                  s1_abort_q <= RXSOF;
                  state_q    <= RXEOF ? ST_IDLE : ST_INFRAME;
               end else begin
                  state_q    <= ST_INFRAME;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Stage 2 inputs: word count for this beat, CRC seed, received CRC field, compare.
   always_comb begin
      if (!s1_eof_q) begin
         nwords_d = 2'd2;
      end else if (s1_half_q) begin
         nwords_d = 2'd0;
      end else begin
         nwords_d = 2'd1;
      end
      crc_base_d = s1_sof_q ? CRCINIT : crc_q;
      rxfield_d  = s1_half_q ? s1_data_q[31:16] : s1_data_q[15:0];
      calc_d     = crc16_final(crc_next_d);
      match_d    = (rxfield_d == calc_d);
      done_d     = s1_valid_q & s1_eof_q;
      abort_d    = s1_valid_q & s1_abort_q;
   end

   crc16_step2 #(
      .CRCPOLY (CRCPOLY)
   ) u_step2 (
      .crc_i    (crc_base_d),
      .data_i   (s1_data_q),
      .nwords_i (nwords_d),
      .crc_o    (crc_next_d)
   );

   // CRC accumulation and registered frame-result outputs.
   always_ff @(posedge CRCCLK or posedge CRCRESET) begin
      if (CRCRESET) begin
         crc_q     <= CRCINIT;
         done_q    <= 1'b0;
         ok_q      <= 1'b0;
         err_q     <= 1'b0;
         abort_q   <= 1'b0;
         rxcrc_q   <= 16'h0000;
         calccrc_q <= 16'h0000;
      end else begin
         done_q  <= done_d;
         ok_q    <= done_d & match_d;
         err_q   <= done_d & ~match_d;
         abort_q <= abort_d;
         if (s1_valid_q) begin
            crc_q <= crc_next_d;
         end else begin
            crc_q <= crc_q;
         end
         if (done_d) begin
            rxcrc_q   <= rxfield_d;
            calccrc_q <= calc_d;
         end else begin
            rxcrc_q   <= rxcrc_q;
            calccrc_q <= calccrc_q;
         end
      end
   end

   assign CRCDONE    = done_q;
   assign CRCOK      = ok_q;
   assign CRCERR     = err_q;
   assign FRAMEABORT = abort_q;
   assign RXCRC      = rxcrc_q;
   assign CALCCRC    = calccrc_q;

`ifdef CRC16_CHECKER_STATS_EN
   logic [15:0] framecount_q;
   logic [15:0] errcount_q;
   logic [15:0] framecount_d;
   logic [15:0] errcount_d;
   logic [16:0] frame_sum_d;
   logic [16:0] err_sum_d;
   logic [1:0]  err_inc_d;

   // Saturating next values; an abort and a bad frame together add two errors.
   always_comb begin
      err_inc_d   = {1'b0, done_d & ~match_d} + {1'b0, abort_d};
      frame_sum_d = {1'b0, framecount_q} + {16'h0000, done_d};
      err_sum_d   = {1'b0, errcount_q} + {15'h0000, err_inc_d};
      framecount_d = frame_sum_d[16] ? 16'hFFFF : frame_sum_d[15:0];
      errcount_d   = err_sum_d[16] ? 16'hFFFF : err_sum_d[15:0];
   end

   // Statistics counters advance on the same edge that raises CRCDONE/FRAMEABORT.
   always_ff @(posedge CRCCLK or posedge CRCRESET) begin
      if (CRCRESET) begin
         framecount_q <= 16'h0000;
         errcount_q   <= 16'h0000;
      end else begin
         framecount_q <= framecount_d;
         errcount_q   <= errcount_d;
      end
   end

   assign FRAMECOUNT = framecount_q;
   assign ERRCOUNT   = errcount_q;
`else
   assign FRAMECOUNT = 16'h0000;
   assign ERRCOUNT   = 16'h0000;
`endif

endmodule
